ccff_chain_loader: RTL and testbench

- Configuration-chain controller for the routing tiles' ccff scan chain (ccff_head → mem cells → ccff_tail).
- Accepts bitstream words from a host over a valid/ready port and serialises exactly CHAIN_LEN bits onto ccff_head.
- Qualifies each chain shift with cfg_shift_en, which the tile-level clock-enable or ICG on the chain uses.
- Reports busy/done; optionally verifies the loaded contents non-destructively.

---
 rtl/ccff_pkg.sv | 22 ++
 rtl/ccff_crc8.sv | 36 +++
 rtl/ccff_chain_loader.sv | 180 ++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types, constants and the serial CRC-8 step for the ccff chain loader.
package ccff_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SHIFT  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } ccff_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One MSB-first step of CRC-8 over a single input bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 accumulator with synchronous clear and bit enable.
module ccff_crc8
  import ccff_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc_o,
  output logic [7:0] crc_next_o
);

  logic [7:0] crc_q, crc_d;

  assign crc_next_o = crc8_step(crc_q, din);
  assign crc_o      = crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC8_INIT;
    end else if (en) begin
      crc_d = crc_next_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC8_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words onto the ccff scan chain, CHAIN_LEN bits per load.
// Define CCFF_LOOPBACK_CHECK_EN to add a recirculating CRC verify pass after the load.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output ccff_state_e       dbg_state
);

  localparam int WB_W = $clog2(WORD_W + 1);

  // Host handshake: a word transfers on a prog_clk edge where wr_valid and wr_ready
  // are both high; wr_ready never depends on wr_valid, and wr_valid is ignored otherwise.

  ccff_state_e       state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WB_W-1:0]   wbits_q, wbits_d, wbits_ld;
  logic [CNT_W-1:0]  left_q, left_d, left_ld;
  logic              head_q, shift_en_q, busy_q, done_q;

  // Bits to take from a freshly loaded word: a partial last word keeps only its top bits.
  assign left_ld  = (state_q == FETCH) ? left_q : left_q - CNT_W'(1);
  assign wbits_ld = (int'(left_ld) >= WORD_W) ? WB_W'(WORD_W) : WB_W'(left_ld);

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    wbits_d  = wbits_q;
    left_d   = left_q;
    wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          left_d  = CNT_W'(CHAIN_LEN);
        end
      end
      FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          sreg_d  = wr_data;
          wbits_d = wbits_ld;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d  = {sreg_q[WORD_W-2:0], 1'b0};
        wbits_d = wbits_q - WB_W'(1);
        left_d  = left_q - CNT_W'(1);
        if (left_q == CNT_W'(1)) begin
`ifdef CCFF_LOOPBACK_CHECK_EN
          state_d = VERIFY;
          left_d  = CNT_W'(CHAIN_LEN);
`else
          state_d = DONE;
`endif
        end else if (wbits_q == WB_W'(1)) begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            sreg_d  = wr_data;
            wbits_d = wbits_ld;
          end else begin
            state_d = FETCH;
          end
        end
      end
      VERIFY: begin
`ifdef CCFF_LOOPBACK_CHECK_EN
        left_d = left_q - CNT_W'(1);
        if (left_q == CNT_W'(1)) begin
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from next-state so they line up with the state they describe.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      wbits_q    <= '0;
      left_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      wbits_q    <= wbits_d;
      left_q     <= left_d;
      head_q     <= (state_d == SHIFT) && sreg_d[WORD_W-1];
      shift_en_q <= (state_d == SHIFT) || (state_d == VERIFY);
      busy_q     <= (state_d == FETCH) || (state_d == SHIFT) || (state_d == VERIFY);
      done_q     <= (state_d == DONE);
    end
  end

`ifdef CCFF_LOOPBACK_CHECK_EN
  logic       crc_clr, err_q, err_d;
  logic [7:0] crc_tx, crc_rx, crc_rx_next, unused_tx_next;

  assign crc_clr = (state_q == IDLE) && start;

  ccff_crc8 u_crc_tx (
    .clk        (prog_clk),
    .rst_n      (pReset),
    .clr        (crc_clr),
    .en         (state_q == SHIFT),
    .din        (sreg_q[WORD_W-1]),
    .crc_o      (crc_tx),
    .crc_next_o (unused_tx_next)
  );

  ccff_crc8 u_crc_rx (
    .clk        (prog_clk),
    .rst_n      (pReset),
    .clr        (crc_clr),
    .en         (state_q == VERIFY),
    .din        (ccff_tail),
    .crc_o      (crc_rx),
    .crc_next_o (crc_rx_next)
  );

  // The last tail bit is folded in combinationally so err lands with the done pulse.
  always_comb begin
    err_d = err_q;
    if (crc_clr) begin
      err_d = 1'b0;
    end else if ((state_q == VERIFY) && (left_q == CNT_W'(1))) begin
      err_d = (crc_rx_next != crc_tx);
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  logic unused_rx;
  assign unused_rx = ^crc_rx;
  assign err       = err_q;
  assign ccff_head = (state_q == VERIFY) ? ccff_tail : head_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
  assign ccff_head   = head_q;
`endif

  assign cfg_shift_en = shift_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader driving a behavioural scan-chain model.
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  localparam int W  = 8;
  localparam int CL = 20;
  localparam int CW = 4 * W;
`ifdef CCFF_LOOPBACK_CHECK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b0;
  logic          start    = 1'b0;
  logic [W-1:0]  wr_data  = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready, ccff_head, ccff_tail, cfg_shift_en, busy, done, err;
  ccff_state_e   dbg_state;

  logic [CL-1:0] chain = '0;
  bit            stuck = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] word_q[$];
  logic [0:0]   exp_q[$];

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(CL)) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .cfg_shift_en (cfg_shift_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset and the external chain: shifts toward the tail when enabled.
  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) if (cfg_shift_en === 1'b1) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = stuck ? 1'b0 : chain[CL-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CRC-8 (0x07, init 0) as the remainder of M(x)*x^8 divided by the generator.
  function automatic logic [7:0] crc_rem(input logic [CL-1:0] msg);
    logic [CL+7:0] m;
    m = {msg, 8'h00};
    for (int i = CL + 7; i >= 8; i--) if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    return m[7:0];
  endfunction

  // Runs one complete load with the words in word_q; called #1 after a posedge.
  task automatic run_load(input string name, input int stall_k, input int restart_at);
    logic [CW-1:0] cat;
    logic [CL-1:0] exp_chain, exp_final;
    logic          exp_err, exp_b, hold, hs;
    logic [W-1:0]  popped;
    int n, exp_total, shifts, first_s, last_s, dones, busy_low, refused, taken, idle_bad;
    bit got_done;
    n = word_q.size();
    cat = '0;
    foreach (word_q[i]) cat = (cat << W) | CW'(word_q[i]);
    exp_chain = CL'(cat >> (n * W - CL));
    exp_q.delete();
    for (int i = 0; i < CL; i++) exp_q.push_back(exp_chain[CL-1-i]);
    exp_total = CL;
    exp_final = exp_chain;
    exp_err   = 1'b0;
    if (LOOPBACK) begin
      exp_total = 2 * CL;
      for (int i = 0; i < CL; i++) exp_q.push_back(stuck ? 1'b0 : exp_chain[CL-1-i]);
      if (stuck) begin
        exp_final = '0;
        exp_err   = (crc_rem(exp_chain) != 8'h00);
      end
    end
    shifts = 0; first_s = -1; last_s = -1; dones = 0; busy_low = 0;
    refused = 0; taken = 0; idle_bad = 0; got_done = 0;
    start = 1'b1;
    @(posedge prog_clk); #1;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      start    = (cyc == restart_at);
      hold     = (taken == 1) && (refused < stall_k);
      wr_valid = (word_q.size() > 0) && !hold;
      wr_data  = wr_valid ? word_q[0] : W'($urandom);
      @(negedge prog_clk);
      if (cyc == 0) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL %s err_cleared: got %b want 0", name, err); end
      end
      if (cfg_shift_en === 1'b1) begin
        shifts++;
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          total++;
          if (ccff_head !== exp_b) begin
            bad++;
            $display("FAIL %s head_bit[%0d]: got %b want %b", name, shifts - 1, ccff_head, exp_b);
          end
        end
      end
      if (done === 1'b1) begin
        got_done = 1;
        dones++;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
        total++;
        if (err !== exp_err) begin bad++; $display("FAIL %s err_at_done: got %b want %b", name, err, exp_err); end
        total++;
        if (cyc != last_s + 1) begin
          bad++;
          $display("FAIL %s done_latency: got cycle %0d want %0d", name, cyc, last_s + 1);
        end
      end else if (busy !== 1'b1) begin
        busy_low++;
      end
      hs = wr_valid && (wr_ready === 1'b1);
      if ((wr_ready === 1'b1) && hold) refused++;
      @(posedge prog_clk); #1;
      if (hs) begin
        popped = word_q.pop_front();
        taken++;
      end
    end
    start    = 1'b0;
    wr_valid = 1'b0;
    total++;
    if (!got_done) begin bad++; $display("FAIL %s done_timeout: got none want 1 pulse", name); end
    for (int k = 0; k < 3; k++) begin
      @(negedge prog_clk);
      if (done === 1'b1) dones++;
      if (cfg_shift_en === 1'b1) shifts++;
      if (wr_ready !== 1'b0 || busy !== 1'b0) idle_bad++;
      @(posedge prog_clk); #1;
    end
    total++;
    if (shifts != exp_total) begin bad++; $display("FAIL %s shift_count: got %0d want %0d", name, shifts, exp_total); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL %s done_count: got %0d want 1", name, dones); end
    total++;
    if (last_s - first_s + 1 != exp_total + stall_k) begin
      bad++;
      $display("FAIL %s shift_span: got %0d want %0d", name, last_s - first_s + 1, exp_total + stall_k);
    end
    total++;
    if (busy_low != 0) begin bad++; $display("FAIL %s busy_gap: got %0d low cycles want 0", name, busy_low); end
    total++;
    if (idle_bad != 0) begin bad++; $display("FAIL %s idle_outputs: got %0d bad cycles want 0", name, idle_bad); end
    total++;
    if (chain !== exp_final) begin bad++; $display("FAIL %s chain: got %h want %h", name, chain, exp_final); end
    total++;
    if (word_q.size() != 0) begin bad++; $display("FAIL %s words_left: got %0d want 0", name, word_q.size()); end
  endtask

  task automatic test_reset();
    pReset = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b1;
    @(negedge prog_clk);
    total++;
    if ({wr_ready, ccff_head, cfg_shift_en, busy, done, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000", {wr_ready, ccff_head, cfg_shift_en, busy, done, err});
    end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = W'($urandom);
    repeat (4) @(posedge prog_clk);
    @(negedge prog_clk);
    total++;
    if (cfg_shift_en !== 1'b1) begin bad++; $display("FAIL reset_pre_shift: got %b want 1", cfg_shift_en); end
    #2 pReset = 1'b0;
    #1;
    total++;
    if ({wr_ready, ccff_head, cfg_shift_en, busy, done, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_async_outputs: got %b want 000000", {wr_ready, ccff_head, cfg_shift_en, busy, done, err});
    end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_async_state: got %0d want %0d", dbg_state, IDLE); end
    wr_valid = 1'b0;
    @(posedge prog_clk); #1;
    pReset = 1'b1;
    @(posedge prog_clk); #1;
  endtask

  task automatic test_single_word();
    word_q = '{8'hA5, 8'h3C, W'($urandom)};
    run_load("a5_first", 0, -1);
  endtask

  task automatic test_multi_word();
    word_q = '{8'hFF, 8'h00, 8'hF0};
    run_load("no_bubble", 0, -1);
  endtask

  task automatic test_stall();
    word_q = '{W'($urandom), W'($urandom), W'($urandom)};
    run_load("stall5", 5, -1);
  endtask

  task automatic test_back_to_back();
    word_q = '{W'($urandom), W'($urandom), W'($urandom)};
    run_load("start_busy", 0, 6);
    word_q = '{W'($urandom), W'($urandom), W'($urandom)};
    run_load("back_to_back", 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      word_q = '{W'($urandom), W'($urandom), W'($urandom)};
      run_load("random", $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 15) : -1);
    end
  endtask

  task automatic test_loopback();
`ifdef CCFF_LOOPBACK_CHECK_EN
    stuck  = 1'b1;
    word_q = '{8'hA5, 8'h5A, 8'hC3};
    run_load("stuck_tail", 0, -1);
    stuck  = 1'b0;
    word_q = '{8'hA5, 8'h5A, 8'hC3};
    run_load("after_stuck", 0, -1);
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_stall();
    test_back_to_back();
    test_random();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
